// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter and sequencer in front of a 64x16 data memory with a
//   registered (1-cycle latency) read port. Requester 0 is the core
//   load/store stage, requester 1 is the debug/DMA loader. One operation is in
//   flight at a time; each completes with a one-cycle rsp_valid pulse to the
//   requester that issued it.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   req_valid_N / req_ready_N   request handshake (ready is combinational)
//   req_we_N, req_addr_N,       operation fields, held stable while valid
//   req_wdata_N
//   rsp_valid_N, rsp_rdata_N    completion pulse; read data held until the
//                               next read response on that port
//   busy                        sequencer not idle
//   mem_*                       memory enables, addresses, write/read data
module dmem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid_0,
  output logic          req_ready_0,
  input  logic          req_we_0,
  input  logic [AW-1:0] req_addr_0,
  input  logic [DW-1:0] req_wdata_0,
  input  logic          req_valid_1,
  output logic          req_ready_1,
  input  logic          req_we_1,
  input  logic [AW-1:0] req_addr_1,
  input  logic [DW-1:0] req_wdata_1,
  output logic          rsp_valid_0,
  output logic [DW-1:0] rsp_rdata_0,
  output logic          rsp_valid_1,
  output logic [DW-1:0] rsp_rdata_1,
  output logic          busy,
  output logic          mem_enable_read,
  output logic          mem_enable_write,
  output logic [AW-1:0] mem_address_read,
  output logic [AW-1:0] mem_address_write,
  output logic [DW-1:0] mem_data_write,
  input  logic [DW-1:0] mem_data_read
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          op_we_q, op_we_d;
  logic [AW-1:0] op_addr_q, op_addr_d;
  logic [DW-1:0] op_wdata_q, op_wdata_d;
  logic          op_port_q, op_port_d;
  logic          rsp_valid_0_q, rsp_valid_0_d;
  logic          rsp_valid_1_q, rsp_valid_1_d;
  logic [DW-1:0] rsp_rdata_0_q, rsp_rdata_0_d;
  logic [DW-1:0] rsp_rdata_1_q, rsp_rdata_1_d;

  logic any_valid;
  logic win_port;
  logic accept;

  // Arbitration: a lone requester wins; on contention the port that was not
  // granted last time wins, so neither side can be starved.
  always_comb begin
    any_valid = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      win_port = ~last_grant_q;
    end else begin
      win_port = req_valid_1;
    end
    accept      = (state_q == IDLE) && any_valid;
    req_ready_0 = accept && !win_port;
    req_ready_1 = accept && win_port;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    op_we_d       = op_we_q;
    op_addr_d     = op_addr_q;
    op_wdata_d    = op_wdata_q;
    op_port_d     = op_port_q;
    rsp_valid_0_d = 1'b0;
    rsp_valid_1_d = 1'b0;
    rsp_rdata_0_d = rsp_rdata_0_q;
    rsp_rdata_1_d = rsp_rdata_1_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_we_d      = win_port ? req_we_1    : req_we_0;
          op_addr_d    = win_port ? req_addr_1  : req_addr_0;
          op_wdata_d   = win_port ? req_wdata_1 : req_wdata_0;
          op_port_d    = win_port;
          last_grant_d = win_port;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (op_we_q) begin
          // The write commits at this edge, so it can be acknowledged now.
          rsp_valid_0_d = !op_port_q;
          rsp_valid_1_d = op_port_q;
          state_d       = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Memory read port registered the data at the ISSUE edge.
        if (op_port_q) begin
          rsp_rdata_1_d = mem_data_read;
          rsp_valid_1_d = 1'b1;
        end else begin
          rsp_rdata_0_d = mem_data_read;
          rsp_valid_0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      op_we_q       <= 1'b0;
      op_addr_q     <= '0;
      op_wdata_q    <= '0;
      op_port_q     <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_rdata_0_q <= '0;
      rsp_rdata_1_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      op_we_q       <= op_we_d;
      op_addr_q     <= op_addr_d;
      op_wdata_q    <= op_wdata_d;
      op_port_q     <= op_port_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      rsp_rdata_0_q <= rsp_rdata_0_d;
      rsp_rdata_1_q <= rsp_rdata_1_d;
    end
  end

  // Memory enables are decoded from state so they are only active in ISSUE;
  // address/data simply present the latched operation at all times.
  assign mem_enable_write  = (state_q == ISSUE) && op_we_q;
  assign mem_enable_read   = (state_q == ISSUE) && !op_we_q;
  assign mem_address_read  = op_addr_q;
  assign mem_address_write = op_addr_q;
  assign mem_data_write    = op_wdata_q;

  assign busy        = (state_q != IDLE);
  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_rdata_0 = rsp_rdata_0_q;
  assign rsp_rdata_1 = rsp_rdata_1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural 64x16 memory that has
//   a registered read port. Inputs change 1 ns after posedge; outputs are
//   sampled on the negedge.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic        req_we_0, req_we_1;
  logic [5:0]  req_addr_0, req_addr_1;
  logic [15:0] req_wdata_0, req_wdata_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [15:0] rsp_rdata_0, rsp_rdata_1;
  logic        busy;
  logic        mem_enable_read, mem_enable_write;
  logic [5:0]  mem_address_read, mem_address_write;
  logic [15:0] mem_data_write, mem_data_read;

  logic        mem_clr;
  logic [15:0] mem [64];

  int n_pass;
  int n_total;

  dmem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_0      (req_valid_0),
    .req_ready_0      (req_ready_0),
    .req_we_0         (req_we_0),
    .req_addr_0       (req_addr_0),
    .req_wdata_0      (req_wdata_0),
    .req_valid_1      (req_valid_1),
    .req_ready_1      (req_ready_1),
    .req_we_1         (req_we_1),
    .req_addr_1       (req_addr_1),
    .req_wdata_1      (req_wdata_1),
    .rsp_valid_0      (rsp_valid_0),
    .rsp_rdata_0      (rsp_rdata_0),
    .rsp_valid_1      (rsp_valid_1),
    .rsp_rdata_1      (rsp_rdata_1),
    .busy             (busy),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_address_read (mem_address_read),
    .mem_address_write(mem_address_write),
    .mem_data_write   (mem_data_write),
    .mem_data_read    (mem_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read (1-cycle latency).
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem_data_read <= 16'h0000;
    end else begin
      if (mem_enable_write) mem[mem_address_write] <= mem_data_write;
      if (mem_enable_read) mem_data_read <= mem[mem_address_read];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ready0"}, req_ready_0, 1'b0);
    chk1({tag, "_ready1"}, req_ready_1, 1'b0);
    chk1({tag, "_en_rd"}, mem_enable_read, 1'b0);
    chk1({tag, "_en_wr"}, mem_enable_write, 1'b0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    mem_clr = 1'b1;
    req_valid_0 = 0; req_we_0 = 0; req_addr_0 = 0; req_wdata_0 = 0;
    req_valid_1 = 0; req_we_1 = 0; req_addr_1 = 0; req_wdata_1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_checks("rst");
    chk1("rst_rspv0", rsp_valid_0, 1'b0);
    chk1("rst_rspv1", rsp_valid_1, 1'b0);
    chk16("rst_rdata0", rsp_rdata_0, 16'h0000);
    chk16("rst_rdata1", rsp_rdata_1, 16'h0000);
    chk16("rst_addr", 16'(mem_address_write), 16'h0000);
    $display("reset: state checked");
    tick();
    reset = 1'b1;
    mem_clr = 1'b0;

    // Test 1: port0 writes 0xBEEF to addr 5
    req_valid_0 = 1; req_we_0 = 1; req_addr_0 = 6'd5; req_wdata_0 = 16'hBEEF;
    @(negedge clk);
    chk1("t1_ready0", req_ready_0, 1'b1);
    chk1("t1_ready1", req_ready_1, 1'b0);
    tick();
    req_valid_0 = 0;
    @(negedge clk);
    chk1("t1_en_wr", mem_enable_write, 1'b1);
    chk1("t1_en_rd", mem_enable_read, 1'b0);
    chk16("t1_waddr", 16'(mem_address_write), 16'd5);
    chk16("t1_wdata", mem_data_write, 16'hBEEF);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_rspv0_early", rsp_valid_0, 1'b0);
    tick();
    @(negedge clk);
    chk1("t1_rspv0", rsp_valid_0, 1'b1);
    chk1("t1_rspv1", rsp_valid_1, 1'b0);
    chk1("t1_en_wr_off", mem_enable_write, 1'b0);
    $display("t1: port0 write addr 5 = beef");

    // Test 2: port1 reads addr 5
    tick();
    chk1("t2_rspv0_pulse", rsp_valid_0, 1'b0);
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 6'd5;
    @(negedge clk);
    chk1("t2_ready1", req_ready_1, 1'b1);
    chk1("t2_ready0", req_ready_0, 1'b0);
    tick();
    req_valid_1 = 0;
    @(negedge clk);
    chk1("t2_en_rd", mem_enable_read, 1'b1);
    chk1("t2_en_wr", mem_enable_write, 1'b0);
    chk16("t2_raddr", 16'(mem_address_read), 16'd5);
    tick();
    @(negedge clk);
    chk1("t2_cap_en_rd", mem_enable_read, 1'b0);
    chk1("t2_cap_rspv1", rsp_valid_1, 1'b0);
    chk1("t2_cap_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk1("t2_rspv1", rsp_valid_1, 1'b1);
    chk16("t2_rdata1", rsp_rdata_1, 16'hBEEF);
    chk1("t2_rspv0", rsp_valid_0, 1'b0);
    $display("t2: port1 read addr 5 -> %h", rsp_rdata_1);

    // Test 3: fresh reset, both ports continuously valid -> grants 0,1,0,1
    tick();
    reset = 0;
    tick();
    reset = 1;
    req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 6'd1;
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 6'd2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        chk1($sformatf("t3_ready0_c%0d", c), req_ready_0, logic'((c / 3) % 2 == 0));
        chk1($sformatf("t3_ready1_c%0d", c), req_ready_1, logic'((c / 3) % 2 == 1));
        if (c > 0) begin
          chk1($sformatf("t3_rspv0_c%0d", c), rsp_valid_0, logic'((c / 3 - 1) % 2 == 0));
          chk1($sformatf("t3_rspv1_c%0d", c), rsp_valid_1, logic'((c / 3 - 1) % 2 == 1));
        end
        $display("t3: cycle %0d grant0=%b grant1=%b", c, req_ready_0, req_ready_1);
      end else begin
        chk1($sformatf("t3_busy_c%0d", c), busy, 1'b1);
        chk1($sformatf("t3_noready_c%0d", c), req_ready_0 | req_ready_1, 1'b0);
      end
      tick();
    end
    req_valid_0 = 0;
    req_valid_1 = 0;
    @(negedge clk);
    chk1("t3_last_rspv1", rsp_valid_1, 1'b1);
    chk1("t3_last_rspv0", rsp_valid_0, 1'b0);
    chk1("t3_last_ready1", req_ready_1, 1'b0);

    // Test 4: port1 alone, three back-to-back reads of addr 5
    tick();
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 6'd5;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk1($sformatf("t4_ready1_c%0d", c), req_ready_1, logic'(c % 3 == 0));
      chk1($sformatf("t4_ready0_c%0d", c), req_ready_0, 1'b0);
      if (c % 3 == 0 && c > 0) begin
        chk1($sformatf("t4_rspv1_c%0d", c), rsp_valid_1, 1'b1);
        chk16($sformatf("t4_rdata1_c%0d", c), rsp_rdata_1, 16'hBEEF);
        $display("t4: cycle %0d port1 response %h", c, rsp_rdata_1);
      end
      tick();
    end
    req_valid_1 = 0;
    @(negedge clk);
    chk1("t4_final_rspv1", rsp_valid_1, 1'b1);
    chk16("t4_final_rdata1", rsp_rdata_1, 16'hBEEF);

    // Test 5: reset asserted during CAPTURE of a port0 read
    tick();
    req_valid_0 = 1; req_we_0 = 0; req_addr_0 = 6'd5;
    @(negedge clk);
    chk1("t5_ready0", req_ready_0, 1'b1);
    tick();
    req_valid_0 = 0;
    tick();
    reset = 0;
    @(negedge clk);
    chk1("t5_cap_busy", busy, 1'b1);
    tick();
    reset = 1;
    @(negedge clk);
    idle_checks("t5_after");
    chk1("t5_rspv0", rsp_valid_0, 1'b0);
    chk16("t5_rdata1_cleared", rsp_rdata_1, 16'h0000);
    tick();
    @(negedge clk);
    chk1("t5_rspv0_late", rsp_valid_0, 1'b0);
    $display("t5: aborted read produced no response");

    // Test 6: contention after reset (port0 must win), write 63 then read 63, read 0
    tick();
    req_valid_0 = 1; req_we_0 = 1; req_addr_0 = 6'd63; req_wdata_0 = 16'h1234;
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 6'd63;
    @(negedge clk);
    chk1("t6_ready0", req_ready_0, 1'b1);
    chk1("t6_ready1", req_ready_1, 1'b0);
    tick();
    req_valid_0 = 0;
    @(negedge clk);
    chk16("t6_waddr", 16'(mem_address_write), 16'd63);
    chk1("t6_en_wr", mem_enable_write, 1'b1);
    tick();
    @(negedge clk);
    chk1("t6_rspv0", rsp_valid_0, 1'b1);
    chk1("t6_ready1_acc", req_ready_1, 1'b1);
    tick();
    req_valid_1 = 0;
    @(negedge clk);
    chk16("t6_raddr", 16'(mem_address_read), 16'd63);
    tick();
    tick();
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 6'd0;
    @(negedge clk);
    chk1("t6_rspv1_a", rsp_valid_1, 1'b1);
    chk16("t6_rdata1_a", rsp_rdata_1, 16'h1234);
    chk1("t6_ready1_b", req_ready_1, 1'b1);
    $display("t6: port1 read addr 63 -> %h", rsp_rdata_1);
    tick();
    req_valid_1 = 0;
    tick();
    tick();
    @(negedge clk);
    chk1("t6_rspv1_b", rsp_valid_1, 1'b1);
    chk16("t6_rdata1_b", rsp_rdata_1, 16'h0000);
    chk1("t6_rspv0_b", rsp_valid_0, 1'b0);
    $display("t6: port1 read addr 0 -> %h", rsp_rdata_1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
